mul_share_arbiter: RTL

- Round-robin scheduler that shares one pipelined single-precision multiplier (fixed latency, always enabled) between N_REQ requesters.
- Accepts at most one operand pair per cycle and drives the multiplier input registers.
- Tracks ownership of every in-flight product with a tag pipeline, then returns each result with a one-hot done strobe to the requester that issued it.
- Sits between the control-system math blocks and the shared multiplier instance.

---
 rtl/mul_share_arbiter_if.sv | 28 ++
 rtl/mul_share_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/mul_share_arbiter_if.sv
// Handshake and datapath bundle between the requesters, the arbiter and the
// shared multiplier. The arbiter takes the slave view; the requester/multiplier
// side takes the master view.
interface mul_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] x_bus;
  logic [N_REQ*WIDTH-1:0] y_bus;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       mul_x;
  logic [WIDTH-1:0]       mul_y;
  logic [WIDTH-1:0]       mul_xy;
  logic [WIDTH-1:0]       xy;
  logic [N_REQ-1:0]       done;
  logic                   busy;

  modport slave (
    input  req, x_bus, y_bus, mul_xy,
    output gnt, mul_x, mul_y, xy, done, busy
  );

  modport master (
    output req, x_bus, y_bus, mul_xy,
    input  gnt, mul_x, mul_y, xy, done, busy
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined multiplier between
// N_REQ requesters. One operand pair is issued per cycle; a tag pipeline
// running alongside the multiplier remembers which requester owns each
// product so the result can be handed back with a one-hot done strobe.
module mul_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int LAT   = 5
) (
  input logic                clk,
  input logic                rst,
  mul_share_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win;
  logic [PW-1:0]    idx;
  logic             found;
  logic [N_REQ-1:0] gnt_w;
  logic [WIDTH-1:0] mul_x_q, mul_x_d;
  logic [WIDTH-1:0] mul_y_q, mul_y_d;
  logic [WIDTH-1:0] xy_q, xy_d;
  logic [LAT-1:0]   vld_q, vld_d;
  logic [PW-1:0]    id_q [LAT];
  logic [PW-1:0]    id_d [LAT];
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;

  // Pick the first requester at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % N_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // One-hot grant; suppressed while reset is held so nothing looks accepted.
  always_comb begin
    gnt_w = '0;
    if (found && rst) gnt_w[win] = 1'b1;
  end

  // Next-state for pointer, operand registers, tag pipe, return stage and busy.
  always_comb begin
    ptr_d   = ptr_q;
    mul_x_d = mul_x_q;
    mul_y_d = mul_y_q;
    if (found) begin
      ptr_d   = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
      mul_x_d = bus.x_bus[win*WIDTH +: WIDTH];
      mul_y_d = bus.y_bus[win*WIDTH +: WIDTH];
    end

    vld_d    = {vld_q[LAT-2:0], found};
    id_d[0]  = win;
    for (int k = 1; k < LAT; k++) id_d[k] = id_q[k-1];

    // The last tag stage lines up with the product currently on mul_xy.
    done_d = '0;
    xy_d   = xy_q;
    if (vld_q[LAT-1]) begin
      done_d[id_q[LAT-1]] = 1'b1;
      xy_d                = bus.mul_xy;
    end

    busy_d = (|vld_q) | found | (|done_d);
  end

  // State registers; reset discards every in-flight tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      mul_x_q <= '0;
      mul_y_q <= '0;
      xy_q    <= '0;
      vld_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      for (int k = 0; k < LAT; k++) id_q[k] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      mul_x_q <= mul_x_d;
      mul_y_q <= mul_y_d;
      xy_q    <= xy_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      for (int k = 0; k < LAT; k++) id_q[k] <= id_d[k];
    end
  end

  assign bus.gnt   = gnt_w;
  assign bus.mul_x = mul_x_q;
  assign bus.mul_y = mul_y_q;
  assign bus.xy    = xy_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
endmodule
